// File: rtl/train_pkg.sv
// Shared definitions for the train sensor timing and prediction stages.
package train_pkg;

    localparam int unsigned TIME_W = 19;

    localparam logic [TIME_W-1:0] MAX_COUNT_DEFAULT = 19'h7FFFF;

    typedef enum logic {
        IDLE,
        TIMING
    } state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for one raw sensor line.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;
    logic rise_q;
    logic rise_d;

    // Reset history high so a line already asserted at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            rise_q  <= rise_d;
        end
    end

    always_comb begin
        rise_d = sync2_q & ~hist_q;
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/sensor_interval_timer.sv
// Measures the S1->S2 interval in milliseconds and reports it with a valid or timeout pulse.
module sensor_interval_timer
    import train_pkg::*;
#(
    parameter int unsigned        CLK_PER_MS = 50000,
    parameter logic [TIME_W-1:0]  MAX_COUNT  = MAX_COUNT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sensor1,
    input  logic              sensor2,
    output logic [TIME_W-1:0] time_out,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    // The start cycle is prescaler phase 0, so N*CLK_PER_MS clocks read as N ms.
    localparam logic [PW-1:0] PRESC_START = (CLK_PER_MS > 1) ? PW'(1) : '0;

    logic s1_rise;
    logic s2_rise;
    logic ms_tick;

    state_e            state_q,   state_d;
    logic [PW-1:0]     presc_q,   presc_d;
    logic [TIME_W-1:0] count_q,   count_d;
    logic [TIME_W-1:0] time_q,    time_d;
    logic              valid_q,   valid_d;
    logic              timeout_q, timeout_d;

    edge_sync u_sync_s1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sensor1),
        .rise_o (s1_rise)
    );

    edge_sync u_sync_s2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (sensor2),
        .rise_o (s2_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            time_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            time_q    <= time_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        time_d    = time_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        ms_tick   = (presc_q == PRESC_LAST);

        unique case (state_q)
            IDLE: begin
                if (s1_rise) begin
                    state_d = TIMING;
                    presc_d = PRESC_START;
                    count_d = '0;
                end
            end
            TIMING: begin
                presc_d = ms_tick ? '0 : presc_q + PW'(1);
                if (ms_tick && (count_q != MAX_COUNT)) begin
                    count_d = count_q + TIME_W'(1);
                end
                // S2 has priority over both the abandon check and an S1 restart.
                if (s2_rise) begin
                    time_d  = count_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else if (count_q == MAX_COUNT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (s1_rise) begin
                    presc_d = PRESC_START;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign time_out = time_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q == TIMING);

endmodule

// File: tb/tb_sensor_interval_timer.sv
// Randomized bench for sensor_interval_timer against an interval-arithmetic reference model.
module tb_sensor_interval_timer;
    import train_pkg::*;

    localparam int unsigned CPM  = 10;
    localparam int unsigned MAXC = 100;
    localparam int unsigned LIMIT = MAXC * CPM;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              s1    = 1'b0;
    logic              s2    = 1'b0;
    logic [TIME_W-1:0] time_out;
    logic              valid;
    logic              timeout;
    logic              busy;

    int unsigned cyc      = 0;
    int unsigned n_valid  = 0;
    int unsigned n_tmo    = 0;
    int unsigned n_both   = 0;
    int unsigned n_cmp    = 0;
    int unsigned n_mis    = 0;

    // Reference model: interval = floor(clocks between S1 and S2 rises / CPM).
    bit          m_busy   = 1'b0;
    int unsigned m_start  = 0;
    int unsigned m_to     = 0;
    int unsigned m_nvalid = 0;
    int unsigned m_ntmo   = 0;

    sensor_interval_timer #(
        .CLK_PER_MS (CPM),
        .MAX_COUNT  (TIME_W'(MAXC))
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sensor1  (s1),
        .sensor2  (s2),
        .time_out (time_out),
        .valid    (valid),
        .timeout  (timeout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid)            n_valid <= n_valid + 1;
            if (timeout)          n_tmo   <= n_tmo + 1;
            if (valid && timeout) n_both  <= n_both + 1;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_settle(input int unsigned now);
        if (m_busy && (now - m_start) >= LIMIT) begin
            m_busy = 1'b0;
            m_ntmo++;
        end
    endfunction

    // Keep clear of the instant where the DUT abandons the interval.
    task automatic guard();
        while (m_busy && (cyc - m_start) >= LIMIT - 15 && (cyc - m_start) < LIMIT + 20) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic raise(input bit a, input bit b, output int unsigned t);
        guard();
        t = cyc;
        m_settle(t);
        if (m_busy) begin
            if (b) begin
                m_to = (t - m_start) / CPM;
                m_nvalid++;
                m_busy = 1'b0;
            end else if (a) begin
                m_start = t;
            end
        end else if (a) begin
            m_busy  = 1'b1;
            m_start = t;
        end
        if (a) s1 = 1'b1;
        if (b) s2 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        if (a) s1 = 1'b0;
        if (b) s2 = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (8) @(posedge clk);
        #1;
        guard();
        m_settle(cyc);
        check({tag, "_nvalid"}, n_valid, m_nvalid);
        check({tag, "_ntmo"}, n_tmo, m_ntmo);
        check({tag, "_time"}, time_out, m_to);
        check({tag, "_busy"}, busy, m_busy);
    endtask

    initial begin
        int unsigned t;
        int unsigned t0;
        int unsigned op;

        repeat (3) @(posedge clk);
        #1;
        check("rst_time", time_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_tmo", timeout, 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Basic interval of 250 clocks.
        raise(1'b1, 1'b0, t0);
        repeat (6) @(posedge clk);
        #1;
        check("r26_busy_mid", busy, 1);
        wait_until(t0 + 250);
        raise(1'b0, 1'b1, t);
        settle_check("r26");
        check("r26_to", time_out, 25);

        // S2 while idle is ignored.
        raise(1'b0, 1'b1, t);
        settle_check("r27");

        // Abandon at MAX_COUNT.
        raise(1'b1, 1'b0, t0);
        wait_until(t0 + LIMIT + 100);
        settle_check("r29");
        check("r29_to", time_out, 25);

        // Restart by a second S1.
        raise(1'b1, 1'b0, t0);
        wait_until(t0 + 50);
        raise(1'b1, 1'b0, t0);
        wait_until(t0 + 70);
        raise(1'b0, 1'b1, t);
        settle_check("r28");
        check("r28_to", time_out, 7);

        // Simultaneous S1 and S2 while timing: S2 wins.
        raise(1'b1, 1'b0, t0);
        wait_until(t0 + 125);
        raise(1'b1, 1'b1, t);
        settle_check("r31");
        check("r31_to", time_out, 12);

        // Randomized mix of events and gaps.
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 4);
            if (op == 4) begin
                repeat ($urandom_range(900, 1200)) @(posedge clk);
                #1;
                settle_check("rnd_gap");
            end else begin
                repeat ($urandom_range(8, 300)) @(posedge clk);
                #1;
                raise(op != 1, op != 0, t);
                settle_check("rnd_op");
            end
        end

        // Reset mid-interval with S1 held high.
        @(posedge clk);
        #1;
        guard();
        s1 = 1'b1;
        m_settle(cyc);
        if (!m_busy) begin
            m_busy  = 1'b1;
            m_start = cyc;
        end else begin
            m_start = cyc;
        end
        repeat (40) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_busy = 1'b0;
        m_to   = 0;
        check("r30_busy", busy, 0);
        check("r30_valid", valid, 0);
        check("r30_tmo", timeout, 0);
        check("r30_time", time_out, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("r30_held_busy", busy, 0);
        s1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        raise(1'b1, 1'b0, t0);
        settle_check("r30_restart");
        wait_until(t0 + 333);
        raise(1'b0, 1'b1, t);
        settle_check("r30_end");
        check("r30_to", time_out, 33);

        check("never_both", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
